id_issue_queue: RTL

- Parametrised successor to the decode-stage fetch latch and load-use stall logic.
- Replaces the single held instruction register with a DEPTH-entry instruction queue between IF and decode.
- Issues the head instruction to decode/EX only when it has no load-use hazard; hazard detection covers loads in flight over a configurable number of downstream stages (LOAD_LAT), not just EX.
- Handles branch flush and downstream stall.

---
 rtl/id_issue_queue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/id_issue_queue.sv
// Decode-stage instruction queue between IF and decode. Issues the head entry only
// when it does not read the destination of a load still inside the LOAD_LAT window.
module id_issue_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ex_stall,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_inst,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_inst,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic                   stallreq_id,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic       trk_v_q  [LOAD_LAT];
    logic       trk_v_d  [LOAD_LAT];
    logic [4:0] trk_rd_q [LOAD_LAT];
    logic [4:0] trk_rd_d [LOAD_LAT];

    logic       empty;
    logic [6:0] opcode;
    logic       use_rs1;
    logic       use_rs2;
    logic       is_load;
    logic       hazard;
    logic       issue;
    logic       enq;

    always_comb begin
        empty    = (count_q == '0);
        out_pc   = empty ? '0 : pc_mem[rd_ptr_q];
        out_inst = empty ? '0 : inst_mem[rd_ptr_q];
        out_rs1  = out_inst[19:15];
        out_rs2  = out_inst[24:20];
        out_rd   = out_inst[11:7];
        opcode   = out_inst[6:0];
        use_rs1  = !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal));
        use_rs2  = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
        is_load  = (opcode == OpLoad);
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (trk_v_q[k] &&
                ((use_rs1 && (out_rs1 != 5'd0) && (out_rs1 == trk_rd_q[k])) ||
                 (use_rs2 && (out_rs2 != 5'd0) && (out_rs2 == trk_rd_q[k])))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & ~empty;
    end

    always_comb begin
        in_ready    = (count_q != Full);
        count       = count_q;
        out_valid   = ~empty & ~hazard;
        stallreq_id = ~empty & hazard;
        issue       = out_valid & ~ex_stall & ~flush;
        enq         = in_valid & in_ready & ~flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({enq, issue})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Tracker is a shift line of in-flight loads; a stalled pipeline freezes it.
    always_comb begin
        trk_v_d  = trk_v_q;
        trk_rd_d = trk_rd_q;
        if (!ex_stall) begin
            for (int k = int'(LOAD_LAT) - 1; k > 0; k--) begin
                trk_v_d[k]  = trk_v_q[k-1];
                trk_rd_d[k] = trk_rd_q[k-1];
            end
            trk_v_d[0]  = issue & is_load & (out_rd != 5'd0);
            trk_rd_d[0] = issue ? out_rd : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < int'(LOAD_LAT); k++) begin
                trk_v_q[k]  <= 1'b0;
                trk_rd_q[k] <= 5'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            trk_v_q  <= trk_v_d;
            trk_rd_q <= trk_rd_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]   <= in_pc;
            inst_mem[wr_ptr_q] <= in_inst;
        end
    end

endmodule
